// File: rtl/map_bilinear_sampler_if.sv
// Point-request / map-RAM / result bundle for the bilinear map sampler.
// The slave modport is the sampler; the master side is upstream, RAM and downstream.
interface map_bilinear_sampler_if #(
   parameter int ADDR_W = 12
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_x;
   logic [31:0]       in_y;
   logic              ram_read_enable;
   logic [ADDR_W-1:0] ram_address;
   logic [7:0]        ram_data;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_value;
   logic [31:0]       out_dx;
   logic [31:0]       out_dy;
   logic              out_of_bounds;

   modport slave (
      input  in_valid, in_x, in_y, ram_data, out_ready,
      output in_ready, ram_read_enable, ram_address,
             out_valid, out_value, out_dx, out_dy, out_of_bounds
   );

   modport master (
      output in_valid, in_x, in_y, ram_data, out_ready,
      input  in_ready, ram_read_enable, ram_address,
             out_valid, out_value, out_dx, out_dy, out_of_bounds
   );
endinterface

// File: rtl/map_bilinear_sampler.sv
// Bilinear occupancy-map sampler: fetches the 2x2 cell neighbourhood of a Q14.18 point
// and returns interpolated value plus x/y gradients in Q14.18.
module map_bilinear_sampler #(
   parameter int MAP_WIDTH  = 128,
   parameter int MAP_HEIGHT = 32
) (
   input logic                   clk,
   input logic                   rst_n,
   map_bilinear_sampler_if.slave bus
);
   localparam int AW = $clog2(MAP_WIDTH * MAP_HEIGHT);

   typedef enum logic [2:0] {
      IDLE, RD00, RD10, RD01, RD11, CAP, CALC, DONE
   } state_e;

   state_e                state_q, state_d;
   logic [AW-1:0]         base_q, base_d;
   logic [17:0]           fx_q, fy_q;
   logic                  oob_q, oob_d;
   logic [7:0]            m00_q, m10_q, m01_q, m11_q;
   logic signed [31:0]    value_q, dx_q, dy_q;
   logic signed [31:0]    value_d, dx_d, dy_d;
   logic                  out_oob_q;

   logic signed [13:0]    x0, y0;
   logic                  accept;
   logic                  ram_en;
   logic [AW-1:0]         ram_addr;

   // a + floor((b-a)*f / 2^18); the 52-bit product keeps the full signed range
   function automatic logic signed [31:0] lerp(input logic signed [31:0] a,
                                               input logic signed [31:0] b,
                                               input logic [17:0] f);
      logic signed [32:0] d;
      logic signed [51:0] p;
      d    = {b[31], b} - {a[31], a};
      p    = d * $signed({1'b0, f});
      lerp = a + 32'(p >>> 18);
   endfunction

   assign x0     = bus.in_x[31:18];
   assign y0     = bus.in_y[31:18];
   assign accept = bus.in_valid && (state_q == IDLE);

   always_comb begin
      oob_d  = 1'b1;
      base_d = '0;
      if (!x0[13] && !y0[13] &&
          ($unsigned(x0) <= 14'(MAP_WIDTH - 2)) &&
          ($unsigned(y0) <= 14'(MAP_HEIGHT - 2))) begin
         oob_d  = 1'b0;
         base_d = AW'(int'($unsigned(y0)) * MAP_WIDTH + int'($unsigned(x0)));
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next state; out-of-range points skip straight to CALC, which emits zeros
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid) state_d = oob_d ? CALC : RD00;
         RD00:    state_d = RD10;
         RD10:    state_d = RD01;
         RD01:    state_d = RD11;
         RD11:    state_d = CAP;
         CAP:     state_d = CALC;
         CALC:    state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      ram_en   = 1'b0;
      ram_addr = '0;
      case (state_q)
         RD00: begin ram_en = 1'b1; ram_addr = base_q;                         end
         RD10: begin ram_en = 1'b1; ram_addr = base_q + AW'(1);                end
         RD01: begin ram_en = 1'b1; ram_addr = base_q + AW'(MAP_WIDTH);        end
         RD11: begin ram_en = 1'b1; ram_addr = base_q + AW'(MAP_WIDTH + 1);    end
         default: ;
      endcase
   end

   assign bus.in_ready        = (state_q == IDLE);
   assign bus.out_valid       = (state_q == DONE);
   assign bus.ram_read_enable = ram_en;
   assign bus.ram_address     = ram_addr;
   assign bus.out_value       = value_q;
   assign bus.out_dx          = dx_q;
   assign bus.out_dy          = dy_q;
   assign bus.out_of_bounds   = out_oob_q;

   always_comb begin
      logic signed [31:0] w00, w10, w01, w11;
      w00     = {6'b0, m00_q, 18'b0};
      w10     = {6'b0, m10_q, 18'b0};
      w01     = {6'b0, m01_q, 18'b0};
      w11     = {6'b0, m11_q, 18'b0};
      value_d = lerp(lerp(w00, w10, fx_q), lerp(w01, w11, fx_q), fy_q);
      dx_d    = lerp(w10 - w00, w11 - w01, fy_q);
      dy_d    = lerp(w01 - w00, w11 - w10, fx_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q    <= '0;
         fx_q      <= '0;
         fy_q      <= '0;
         oob_q     <= 1'b0;
         m00_q     <= '0;
         m10_q     <= '0;
         m01_q     <= '0;
         m11_q     <= '0;
         value_q   <= '0;
         dx_q      <= '0;
         dy_q      <= '0;
         out_oob_q <= 1'b0;
      end else begin
         if (accept) begin
            base_q <= base_d;
            fx_q   <= bus.in_x[17:0];
            fy_q   <= bus.in_y[17:0];
            oob_q  <= oob_d;
         end
         // each read's data lands one state after its strobe
         case (state_q)
            RD10: m00_q <= bus.ram_data;
            RD01: m10_q <= bus.ram_data;
            RD11: m01_q <= bus.ram_data;
            CAP:  m11_q <= bus.ram_data;
            CALC: begin
               out_oob_q <= oob_q;
               value_q   <= oob_q ? '0 : value_d;
               dx_q      <= oob_q ? '0 : dx_d;
               dy_q      <= oob_q ? '0 : dy_d;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_map_bilinear_sampler.sv
// Self-checking bench for map_bilinear_sampler: directed scenarios plus random points
// against an integer-arithmetic reference of the bilinear rules.
module tb_map_bilinear_sampler;
   localparam int W = 128;
   localparam int H = 32;
   localparam int ONE = 262144;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   map_bilinear_sampler_if #(.ADDR_W(12)) bus();
   map_bilinear_sampler #(.MAP_WIDTH(W), .MAP_HEIGHT(H)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   logic [7:0] mem [W*H];
   int         addr_log[$];
   int         n_checks = 0;
   int         n_fail = 0;

   // map RAM: one-cycle read latency
   always @(posedge clk) begin
      if (bus.ram_read_enable) begin
         bus.ram_data <= mem[bus.ram_address];
         addr_log.push_back(int'(bus.ram_address));
      end
   end

   function automatic int fxp(real r);
      return int'(r * 262144.0);
   endfunction

   function automatic longint lerp_m(longint a, longint b, longint f);
      return a + (((b - a) * f) >>> 18);
   endfunction

   task automatic model(input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] v, output logic [31:0] dx,
                        output logic [31:0] dy, output logic oob);
      int x0, y0;
      longint fx, fy, m00, m10, m01, m11;
      x0 = $signed(x) >>> 18;
      y0 = $signed(y) >>> 18;
      fx = longint'(x & 32'h3FFFF);
      fy = longint'(y & 32'h3FFFF);
      oob = (x0 < 0) || (x0 > W - 2) || (y0 < 0) || (y0 > H - 2);
      v = 0; dx = 0; dy = 0;
      if (!oob) begin
         m00 = longint'(mem[y0*W + x0])       * ONE;
         m10 = longint'(mem[y0*W + x0 + 1])   * ONE;
         m01 = longint'(mem[(y0+1)*W + x0])   * ONE;
         m11 = longint'(mem[(y0+1)*W + x0 + 1]) * ONE;
         v  = 32'(lerp_m(lerp_m(m00, m10, fx), lerp_m(m01, m11, fx), fy));
         dx = 32'(lerp_m(m10 - m00, m11 - m01, fy));
         dy = 32'(lerp_m(m01 - m00, m11 - m10, fx));
      end
   endtask

   // drives one request, returns edges from acceptance to out_valid (-1 on timeout)
   task automatic run_point(input logic [31:0] x, input logic [31:0] y, output int lat,
                            output logic [31:0] v, output logic [31:0] dx,
                            output logic [31:0] dy, output logic oob);
      addr_log.delete();
      @(negedge clk);
      bus.in_x = x; bus.in_y = y; bus.in_valid = 1'b1;
      @(posedge clk); #1 bus.in_valid = 1'b0;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (bus.out_valid) begin lat = k; break; end
      end
      v = bus.out_value; dx = bus.out_dx; dy = bus.out_dy; oob = bus.out_of_bounds;
   endtask

   task automatic release_out();
      @(negedge clk) bus.out_ready = 1'b1;
      @(posedge clk); #1 bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
      n_checks++; if (bus.ram_read_enable !== 1'b0 || bus.ram_address !== 12'd0) begin n_fail++; $display("FAIL reset_ram got en=%b addr=%0d want 0/0", bus.ram_read_enable, bus.ram_address); end
      n_checks++; if ({bus.out_value, bus.out_dx, bus.out_dy, bus.out_of_bounds} !== 97'd0) begin n_fail++; $display("FAIL reset_outputs got %h %h %h %b want zeros", bus.out_value, bus.out_dx, bus.out_dy, bus.out_of_bounds); end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset got rdy=%b vld=%b want 1/0", bus.in_ready, bus.out_valid); end
   endtask

   task automatic test_basic();
      int lat; logic [31:0] v, dx, dy; logic oob;
      int exp_a[4];
      exp_a = '{389, 390, 517, 518};
      mem[389] = 8'd0; mem[390] = 8'd100; mem[517] = 8'd0; mem[518] = 8'd100;
      run_point(fxp(5.5), fxp(3.25), lat, v, dx, dy, oob);
      n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL basic_latency got %0d want 6", lat); end
      n_checks++; if (addr_log.size() !== 4) begin n_fail++; $display("FAIL basic_read_count got %0d want 4", addr_log.size()); end
      for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
         n_checks++; if (addr_log[i] !== exp_a[i]) begin n_fail++; $display("FAIL basic_addr[%0d] got %0d want %0d", i, addr_log[i], exp_a[i]); end
      end
      n_checks++; if (v !== 32'(50*ONE)) begin n_fail++; $display("FAIL basic_value got %h want %h", v, 32'(50*ONE)); end
      n_checks++; if (dx !== 32'(100*ONE)) begin n_fail++; $display("FAIL basic_dx got %h want %h", dx, 32'(100*ONE)); end
      n_checks++; if (dy !== 32'd0 || oob !== 1'b0) begin n_fail++; $display("FAIL basic_dy_oob got %h/%b want 0/0", dy, oob); end
      release_out();
   endtask

   task automatic test_vertical();
      int lat; logic [31:0] v, dx, dy; logic oob;
      mem[1*W+2] = 8'd0; mem[1*W+3] = 8'd0; mem[2*W+2] = 8'd200; mem[2*W+3] = 8'd200;
      run_point(fxp(2.0), fxp(1.5), lat, v, dx, dy, oob);
      n_checks++; if (v !== 32'(100*ONE)) begin n_fail++; $display("FAIL vert_value got %h want %h", v, 32'(100*ONE)); end
      n_checks++; if (dx !== 32'd0) begin n_fail++; $display("FAIL vert_dx got %h want 0", dx); end
      n_checks++; if (dy !== 32'(200*ONE)) begin n_fail++; $display("FAIL vert_dy got %h want %h", dy, 32'(200*ONE)); end
      release_out();
   endtask

   task automatic test_bounds();
      int lat; logic [31:0] v, dx, dy, ev, edx, edy; logic oob, eoob;
      logic [31:0] bx[4], by[4];
      run_point(fxp(126.9), fxp(30.0), lat, v, dx, dy, oob);
      model(fxp(126.9), fxp(30.0), ev, edx, edy, eoob);
      n_checks++; if (lat !== 6 || oob !== 1'b0 || addr_log.size() !== 4) begin n_fail++; $display("FAIL edge_in_range got lat=%0d oob=%b reads=%0d want 6/0/4", lat, oob, addr_log.size()); end
      n_checks++; if ({v, dx, dy} !== {ev, edx, edy}) begin n_fail++; $display("FAIL edge_in_range_result got %h %h %h want %h %h %h", v, dx, dy, ev, edx, edy); end
      release_out();
      bx = '{fxp(127.0), fxp(3.0), fxp(-0.5), fxp(3.0)};
      by = '{fxp(3.0), fxp(-0.5), fxp(3.0), fxp(31.0)};
      for (int i = 0; i < 4; i++) begin
         run_point(bx[i], by[i], lat, v, dx, dy, oob);
         n_checks++; if (lat !== 1 || oob !== 1'b1) begin n_fail++; $display("FAIL oob[%0d] got lat=%0d oob=%b want 1/1", i, lat, oob); end
         n_checks++; if ({v, dx, dy} !== 96'd0) begin n_fail++; $display("FAIL oob_zero[%0d] got %h %h %h want zeros", i, v, dx, dy); end
         n_checks++; if (addr_log.size() !== 0) begin n_fail++; $display("FAIL oob_reads[%0d] got %0d want 0", i, addr_log.size()); end
         release_out();
      end
   endtask

   task automatic test_backpressure();
      int lat; logic [31:0] v, dx, dy, ev, edx, edy; logic oob, eoob;
      logic [31:0] ax, ay, bx, by;
      ax = fxp(10.75); ay = fxp(7.125); bx = fxp(40.3); by = fxp(20.6);
      run_point(ax, ay, lat, v, dx, dy, oob);
      model(ax, ay, ev, edx, edy, eoob);
      n_checks++; if ({v, dx, dy, oob} !== {ev, edx, edy, eoob}) begin n_fail++; $display("FAIL bp_first got %h %h %h want %h %h %h", v, dx, dy, ev, edx, edy); end
      addr_log.delete();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); bus.in_x = bx; bus.in_y = by; bus.in_valid = 1'b1;
         @(posedge clk); #1;
         n_checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d] got vld=%b rdy=%b want 1/0", c, bus.out_valid, bus.in_ready); end
         n_checks++; if ({bus.out_value, bus.out_dx, bus.out_dy} !== {v, dx, dy}) begin n_fail++; $display("FAIL bp_stable[%0d] got %h want %h", c, bus.out_value, v); end
      end
      @(negedge clk) bus.in_valid = 1'b0;
      n_checks++; if (addr_log.size() !== 0) begin n_fail++; $display("FAIL bp_ignored_reads got %0d want 0", addr_log.size()); end
      release_out();
      n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got vld=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); end
      run_point(bx, by, lat, v, dx, dy, oob);
      model(bx, by, ev, edx, edy, eoob);
      n_checks++; if (lat !== 6 || {v, dx, dy, oob} !== {ev, edx, edy, eoob}) begin n_fail++; $display("FAIL bp_second got lat=%0d %h %h %h want 6 %h %h %h", lat, v, dx, dy, ev, edx, edy); end
      release_out();
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] v, dx, dy, ev, edx, edy; logic oob, eoob;
      logic stale;
      @(negedge clk); bus.in_x = fxp(20.5); bus.in_y = fxp(9.5); bus.in_valid = 1'b1;
      @(posedge clk); #1 bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if (bus.ram_read_enable !== 1'b0 || bus.ram_address !== 12'd0) begin n_fail++; $display("FAIL midrst_ram got en=%b addr=%0d want 0/0", bus.ram_read_enable, bus.ram_address); end
      n_checks++; if ({bus.out_valid, bus.out_value, bus.out_dx, bus.out_dy, bus.out_of_bounds} !== 98'd0) begin n_fail++; $display("FAIL midrst_outputs got vld=%b %h %h %h want zeros", bus.out_valid, bus.out_value, bus.out_dx, bus.out_dy); end
      @(negedge clk) rst_n = 1'b1;
      stale = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) stale = 1'b1;
      end
      n_checks++; if (stale !== 1'b0) begin n_fail++; $display("FAIL midrst_stale got out_valid/in_ready disturbed=%b want 0", stale); end
      run_point(fxp(20.5), fxp(9.5), lat, v, dx, dy, oob);
      model(fxp(20.5), fxp(9.5), ev, edx, edy, eoob);
      n_checks++; if (lat !== 6 || {v, dx, dy, oob} !== {ev, edx, edy, eoob}) begin n_fail++; $display("FAIL midrst_after got lat=%0d %h want 6 %h", lat, v, ev); end
      release_out();
   endtask

   task automatic test_random();
      int lat, sel; logic [31:0] x, y, v, dx, dy, ev, edx, edy; logic oob, eoob;
      for (int n = 0; n < 1000; n++) begin
         sel = $urandom_range(0, 9);
         if (sel < 8) begin
            x = $urandom_range(0, (W-1)*ONE - 1);
            y = $urandom_range(0, (H-1)*ONE - 1);
         end else if (sel == 8) begin
            x = $urandom_range(0, (W+2)*ONE) - ONE;
            y = $urandom_range(0, (H+2)*ONE) - ONE;
         end else begin
            x = $urandom(); y = $urandom();
         end
         if (n % 50 == 0) for (int i = 0; i < W*H; i++) mem[i] = 8'($urandom());
         run_point(x, y, lat, v, dx, dy, oob);
         model(x, y, ev, edx, edy, eoob);
         n_checks++; if (oob !== eoob || lat !== (eoob ? 1 : 6)) begin n_fail++; $display("FAIL rnd_ctrl[%0d] x=%h y=%h got oob=%b lat=%0d want oob=%b", n, x, y, oob, lat, eoob); end
         n_checks++; if (v !== ev) begin n_fail++; $display("FAIL rnd_value[%0d] x=%h y=%h got %h want %h", n, x, y, v, ev); end
         n_checks++; if (dx !== edx) begin n_fail++; $display("FAIL rnd_dx[%0d] x=%h y=%h got %h want %h", n, x, y, dx, edx); end
         n_checks++; if (dy !== edy) begin n_fail++; $display("FAIL rnd_dy[%0d] x=%h y=%h got %h want %h", n, x, y, dy, edy); end
         release_out();
      end
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.out_ready = 1'b0;
      for (int i = 0; i < W*H; i++) mem[i] = 8'($urandom());
      test_reset();
      test_basic();
      test_vertical();
      test_bounds();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
